// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing one variable-latency memory bus
//            between the fetch port and the data port, with timeout abort.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            d_err,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack,
    output logic            busy,
    output logic            grant_d
);

    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_last_d;
    logic        w_pick_d;

    // Data wins when it is alone, or on a tie when fetch had the last grant.
    assign w_pick_d = d_req & (~i_req | ~r_last_d);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_last_d <= 1'b1;
            i_rdata  <= '0;
            i_ack    <= 1'b0;
            i_err    <= 1'b0;
            d_rdata  <= '0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_be     <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            busy     <= 1'b0;
            grant_d  <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        grant_d  <= w_pick_d;
                        r_last_d <= w_pick_d;
                        busy     <= 1'b1;
                        m_req    <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                        if (w_pick_d) begin
                            m_we    <= d_we;
                            m_be    <= d_be;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we    <= 1'b0;
                            m_be    <= '1;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    // Acknowledge takes priority over a timeout in the same cycle.
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        r_state <= ST_RESP;
                        if (grant_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= m_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        m_req   <= 1'b0;
                        r_state <= ST_RESP;
                        if (grant_d) begin
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_err   <= 1'b1;
                            i_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    busy    <= 1'b0;
                    grant_d <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter: directed requests, a queued
//            memory model and a response monitor.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int c_to = 4;

    logic        clk;
    logic        nrst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        busy;
    logic        grant_d;
    logic        mem_ack;
    logic        late_ack;

    assign m_ack = mem_ack | late_ack;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(c_to)) u_dut (
        .clk(clk), .nrst(nrst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .grant_d(grant_d)
    );

    typedef struct {
        logic        port_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;     // cycles after m_req before ack, -1 = never
        int          cycles;  // expected m_req-high cycles, -1 = not checked
    } mem_t;

    typedef struct {
        logic        port_d;
        logic        err;
        logic [31:0] rdata;
        int          gap;     // expected cycles since previous response, 0 = not checked
    } resp_t;

    mem_t  mq[$];
    resp_t rq[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    n_resp   = 0;
    int    cyc      = 0;
    int    last_resp_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mem(input logic pd, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int lat, input int cycles);
        mem_t e;
        e.port_d = pd; e.we = we; e.be = be; e.addr = addr;
        e.wdata = wdata; e.rdata = rdata; e.lat = lat; e.cycles = cycles;
        mq.push_back(e);
    endtask

    task automatic push_resp(input logic pd, input logic err, input logic [31:0] rdata, input int gap);
        resp_t e;
        e.port_d = pd; e.err = err; e.rdata = rdata; e.gap = gap;
        rq.push_back(e);
    endtask

    task automatic wait_resps(input int n, input int maxc);
        int tgt;
        int k;
        tgt = n_resp + n;
        k = 0;
        while (n_resp < tgt && k < maxc) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("resp_wait_timeout", 32'(n_resp >= tgt), 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: checks each issued request and acknowledges after its latency.
    initial begin : mem_model
        mem_t cur;
        logic in_tx;
        logic have_cur;
        int   ccount;
        mem_ack = 1'b0;
        m_rdata = '0;
        in_tx = 1'b0;
        have_cur = 1'b0;
        ccount = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!nrst) begin
                in_tx = 1'b0;
            end else begin
                if (m_req && !in_tx) begin
                    in_tx = 1'b1;
                    ccount = 0;
                    if (mq.size() == 0) begin
                        have_cur = 1'b0;
                        chk("mem_unexpected_req", m_addr, 32'hFFFF_FFFF);
                    end else begin
                        have_cur = 1'b1;
                        cur = mq.pop_front();
                        chk("m_we", 32'(m_we), 32'(cur.we));
                        chk("m_be", 32'(m_be), 32'(cur.be));
                        chk("m_addr", m_addr, cur.addr);
                        chk("m_wdata", m_wdata, cur.wdata);
                        chk("grant_d", 32'(grant_d), 32'(cur.port_d));
                        chk("busy_in_busy", 32'(busy), 32'd1);
                    end
                end
                if (in_tx) begin
                    if (m_req) begin
                        if (have_cur && cur.lat == ccount) begin
                            mem_ack = 1'b1;
                            m_rdata = cur.rdata;
                        end
                        ccount++;
                    end else begin
                        in_tx = 1'b0;
                        if (have_cur && cur.cycles >= 0)
                            chk("m_req_cycles", 32'(ccount), 32'(cur.cycles));
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every ack/err pulse.
    initial begin : monitor
        resp_t e;
        logic  got_d;
        logic  got_err;
        logic [31:0] got_rdata;
        forever begin
            @(negedge clk);
            if (nrst && (i_ack || i_err || d_ack || d_err)) begin
                chk("resp_exclusive", 32'((i_ack | i_err) & (d_ack | d_err)), 32'd0);
                got_d     = d_ack | d_err;
                got_err   = got_d ? d_err : i_err;
                got_rdata = got_d ? d_rdata : i_rdata;
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 32'({got_d, got_err}), 32'hFFFF_FFFF);
                end else begin
                    e = rq.pop_front();
                    chk("resp_port", 32'(got_d), 32'(e.port_d));
                    chk("resp_err", 32'(got_err), 32'(e.err));
                    chk("resp_rdata", got_rdata, e.rdata);
                    if (e.gap > 0)
                        chk("resp_gap", 32'(cyc - last_resp_cyc), 32'(e.gap));
                end
                last_resp_cyc = cyc;
                n_resp++;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        nrst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; late_ack = 1'b0;
        #3 nrst = 1'b0;
        #1;
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_d", 32'(grant_d), 32'd0);
        chk("rst_acks", 32'({i_ack, i_err, d_ack, d_err}), 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // First tie after reset goes to fetch, then the pending store.
        push_mem(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h0000_0013, 0, 1);
        push_resp(1'b0, 1'b0, 32'h0000_0013, 0);
        push_mem(1'b1, 1'b1, 4'h3, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_5555, 1, 2);
        push_resp(1'b1, 1'b0, 32'h0000_5555, 0);
        @(negedge clk);
        i_addr = 32'h10; i_req = 1'b1;
        d_we = 1'b1; d_be = 4'h3; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        wait_resps(1, 20);
        i_req = 1'b0;
        wait_resps(1, 20);
        d_req = 1'b0;

        // Last grant was data, so the next tie goes to fetch again.
        push_mem(1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h0000_0A01, 0, 1);
        push_resp(1'b0, 1'b0, 32'h0000_0A01, 0);
        push_mem(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'h0000_0B02, 0, 1);
        push_resp(1'b1, 1'b0, 32'h0000_0B02, 0);
        @(negedge clk);
        i_addr = 32'h20; i_req = 1'b1;
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'h0; d_req = 1'b1;
        wait_resps(1, 20);
        i_req = 1'b0;
        wait_resps(1, 20);
        d_req = 1'b0;

        // Continuous contention with zero-wait memory: strict alternation, 3 cycles apart.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                push_mem(1'b0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'h0000_00A0 + 32'(k), 0, 1);
                push_resp(1'b0, 1'b0, 32'h0000_00A0 + 32'(k), (k == 0) ? 0 : 3);
            end else begin
                push_mem(1'b1, 1'b1, 4'hF, 32'h0000_3000, 32'h1122_3344, 32'h0000_00D0 + 32'(k), 0, 1);
                push_resp(1'b1, 1'b0, 32'h0000_00D0 + 32'(k), 3);
            end
        end
        @(negedge clk);
        i_addr = 32'h200; i_req = 1'b1;
        d_we = 1'b1; d_be = 4'hF; d_addr = 32'h3000; d_wdata = 32'h1122_3344; d_req = 1'b1;
        wait_resps(6, 60);
        i_req = 1'b0; d_req = 1'b0;

        // Fetch only, memory acks two cycles after m_req.
        push_mem(1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0000_0013, 2, 3);
        push_resp(1'b0, 1'b0, 32'h0000_0013, 0);
        @(negedge clk);
        i_addr = 32'h100; i_req = 1'b1;
        wait_resps(1, 20);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("i_rdata_hold", i_rdata, 32'h0000_0013);

        // Data load that never gets acked times out with an error and zero data.
        push_mem(1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'h0, -1, c_to);
        push_resp(1'b1, 1'b1, 32'h0, 0);
        @(negedge clk);
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500; d_wdata = 32'h0; d_req = 1'b1;
        wait_resps(1, 20);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_busy", 32'(busy), 32'd0);
        chk("late_ack_m_req", 32'(m_req), 32'd0);
        chk("d_rdata_after_err", d_rdata, 32'd0);

        // Ack arriving on the final allowed cycle still completes normally.
        push_mem(1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h0000_0093, c_to - 1, c_to);
        push_resp(1'b0, 1'b0, 32'h0000_0093, 0);
        @(negedge clk);
        i_addr = 32'h104; i_req = 1'b1;
        wait_resps(1, 20);
        i_req = 1'b0;

        // Asynchronous reset in the middle of a transaction.
        push_mem(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0, 32'h0, -1, -1);
        @(negedge clk);
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h600; d_req = 1'b1;
        for (int k = 0; k < 10 && !m_req; k++) @(negedge clk);
        chk("mid_rst_m_req_seen", 32'(m_req), 32'd1);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_m_req", 32'(m_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant_d", 32'(grant_d), 32'd0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        push_mem(1'b0, 1'b0, 4'hF, 32'h0000_0700, 32'h0, 32'h0000_0077, 1, 2);
        push_resp(1'b0, 1'b0, 32'h0000_0077, 0);
        push_mem(1'b1, 1'b0, 4'hF, 32'h0000_0800, 32'h0, 32'h0000_0088, 0, 1);
        push_resp(1'b1, 1'b0, 32'h0000_0088, 0);
        @(negedge clk);
        i_addr = 32'h700; i_req = 1'b1;
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h800; d_req = 1'b1;
        wait_resps(1, 20);
        i_req = 1'b0;
        wait_resps(1, 20);
        d_req = 1'b0;
        repeat (4) @(negedge clk);

        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        chk("mem_queue_empty", 32'(mq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
